// File: rtl/axi_mem_responder.sv
// AXI4 slave memory model: one write and one read burst in flight at a time, independent
// read/write FSMs, FIXED/INCR/WRAP addressing and a programmable read latency.
package axi_mem_responder_pkg;
    localparam int unsigned AddrWidth = 64;
    localparam int unsigned IdWidth   = 4;
    localparam int unsigned DataWidth = 64;
    localparam int unsigned StrbWidth = DataWidth / 8;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
    } ax_chan_t;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic [StrbWidth-1:0] strb;
        logic                 last;
    } w_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic [1:0]         resp;
    } b_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [DataWidth-1:0] data;
        logic [1:0]           resp;
        logic                 last;
    } r_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    w_ready;
        b_chan_t b;
        logic    b_valid;
        logic    ar_ready;
        r_chan_t r;
        logic    r_valid;
    } axi_resp_t;
endpackage

module axi_mem_responder #(
    parameter type         mst_req_t   = axi_mem_responder_pkg::axi_req_t,
    parameter type         mst_resp_t  = axi_mem_responder_pkg::axi_resp_t,
    parameter int unsigned DataWidth   = 64,
    parameter int unsigned NumWords    = 1024,
    parameter int unsigned ReadLatency = 2
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  mst_req_t  axi_req_i,
    output mst_resp_t axi_resp_o
);
    localparam int unsigned AW   = axi_mem_responder_pkg::AddrWidth;
    localparam int unsigned IdW  = axi_mem_responder_pkg::IdWidth;
    localparam int unsigned Bpb  = DataWidth / 8;
    localparam int unsigned OffW = $clog2(Bpb);
    localparam int unsigned IdxW = $clog2(NumWords);

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_WAIT = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstWrap  = 2'b10;
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;

    // Valid/ready: a beat transfers on a rising edge where both valid and ready are 1;
    // payload is meaningful only while valid=1 and is held stable until the transfer.

    function automatic logic in_range(input logic [AW-1:0] a);
        return a[AW-1:OffW+IdxW] == '0;
    endfunction

    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] addr, input logic [2:0] size,
                                               input logic [7:0] len, input logic [1:0] burst);
        logic [AW-1:0] step;
        logic [AW-1:0] incr;
        logic [AW-1:0] span;
        logic [AW-1:0] lo;
        logic          wrap_ok;
        step    = AW'(1) << size;
        incr    = (addr & ~(step - AW'(1))) + step;
        span    = step * (AW'(len) + AW'(1));
        lo      = addr & ~(span - AW'(1));
        wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        next_addr = incr;
        if (burst == BurstFixed) begin
            next_addr = addr;
        end else if (burst == BurstWrap && wrap_ok && incr == lo + span) begin
            next_addr = lo;
        end
    endfunction

    logic [DataWidth-1:0] mem_q [NumWords];

    // Readies stay low for the cycle after reset even though the FSMs already sit in IDLE.
    logic            rdy_en_q;

    logic [1:0]      w_state_q, w_state_d;
    logic [IdW-1:0]  w_id_q, w_id_d;
    logic [AW-1:0]   w_addr_q, w_addr_d;
    logic [7:0]      w_len_q, w_len_d;
    logic [2:0]      w_size_q, w_size_d;
    logic [1:0]      w_burst_q, w_burst_d;
    logic [8:0]      w_cnt_q, w_cnt_d;
    logic            w_err_q, w_err_d;

    logic [1:0]      r_state_q, r_state_d;
    logic [IdW-1:0]  r_id_q, r_id_d;
    logic [AW-1:0]   r_addr_q, r_addr_d;
    logic [7:0]      r_len_q, r_len_d;
    logic [2:0]      r_size_q, r_size_d;
    logic [1:0]      r_burst_q, r_burst_d;
    logic [7:0]      r_cnt_q, r_cnt_d;
    logic [3:0]      r_lat_q, r_lat_d;

    logic aw_ready, w_ready, b_valid, ar_ready, r_valid;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic w_in_range, r_in_range, r_last, mem_we;
    logic [IdxW-1:0] w_idx, r_idx;

    assign aw_ready   = rdy_en_q && (w_state_q == W_IDLE);
    assign w_ready    = rdy_en_q && (w_state_q == W_DATA);
    assign b_valid    = (w_state_q == W_RESP);
    assign ar_ready   = rdy_en_q && (r_state_q == R_IDLE);
    assign r_valid    = (r_state_q == R_DATA);

    assign aw_hs      = aw_ready && axi_req_i.aw_valid;
    assign w_hs       = w_ready && axi_req_i.w_valid;
    assign b_hs       = b_valid && axi_req_i.b_ready;
    assign ar_hs      = ar_ready && axi_req_i.ar_valid;
    assign r_hs       = r_valid && axi_req_i.r_ready;

    assign w_in_range = in_range(w_addr_q);
    assign r_in_range = in_range(r_addr_q);
    assign w_idx      = w_addr_q[OffW+IdxW-1:OffW];
    assign r_idx      = r_addr_q[OffW+IdxW-1:OffW];
    assign r_last     = (r_cnt_q == r_len_q);
    assign mem_we     = w_hs && w_in_range && !rst_i;

    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_size_d  = w_size_q;
        w_burst_d = w_burst_q;
        w_cnt_d   = w_cnt_q;
        w_err_d   = w_err_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    w_id_d    = axi_req_i.aw.id;
                    w_addr_d  = axi_req_i.aw.addr;
                    w_len_d   = axi_req_i.aw.len;
                    w_size_d  = axi_req_i.aw.size;
                    w_burst_d = axi_req_i.aw.burst;
                    w_cnt_d   = '0;
                    w_err_d   = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (w_hs) begin
                    w_addr_d = next_addr(w_addr_q, w_size_q, w_len_q, w_burst_q);
                    w_cnt_d  = w_cnt_q + 9'd1;
                    w_err_d  = w_err_q | ~w_in_range;
                    if (axi_req_i.w.last) begin
                        // Beat-count mismatch only becomes known when last arrives.
                        w_err_d   = w_err_q | ~w_in_range | (w_cnt_q != {1'b0, w_len_q});
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (b_hs) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_size_d  = r_size_q;
        r_burst_d = r_burst_q;
        r_cnt_d   = r_cnt_q;
        r_lat_d   = r_lat_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    r_id_d    = axi_req_i.ar.id;
                    r_addr_d  = axi_req_i.ar.addr;
                    r_len_d   = axi_req_i.ar.len;
                    r_size_d  = axi_req_i.ar.size;
                    r_burst_d = axi_req_i.ar.burst;
                    r_cnt_d   = '0;
                    r_lat_d   = 4'(ReadLatency);
                    r_state_d = (ReadLatency == 0) ? R_DATA : R_WAIT;
                end
            end
            R_WAIT: begin
                r_lat_d = r_lat_q - 4'd1;
                if (r_lat_q <= 4'd1) begin
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (r_hs) begin
                    r_addr_d = next_addr(r_addr_q, r_size_q, r_len_q, r_burst_q);
                    r_cnt_d  = r_cnt_q + 8'd1;
                    if (r_last) begin
                        r_state_d = R_IDLE;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdy_en_q  <= 1'b0;
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_size_q  <= '0;
            w_burst_q <= '0;
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_size_q  <= '0;
            r_burst_q <= '0;
            r_cnt_q   <= '0;
            r_lat_q   <= '0;
        end else begin
            rdy_en_q  <= 1'b1;
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_size_q  <= w_size_d;
            w_burst_q <= w_burst_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_size_q  <= r_size_d;
            r_burst_q <= r_burst_d;
            r_cnt_q   <= r_cnt_d;
            r_lat_q   <= r_lat_d;
        end
    end

    // Memory survives reset; a write lands at the edge, so a same-cycle read sees old data.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int i = 0; i < Bpb; i++) begin
                if (axi_req_i.w.strb[i]) begin
                    mem_q[w_idx][i*8 +: 8] <= axi_req_i.w.data[i*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        axi_resp_o          = '0;
        axi_resp_o.aw_ready = aw_ready;
        axi_resp_o.w_ready  = w_ready;
        axi_resp_o.b_valid  = b_valid;
        axi_resp_o.ar_ready = ar_ready;
        axi_resp_o.r_valid  = r_valid;
        if (b_valid) begin
            axi_resp_o.b.id   = w_id_q;
            axi_resp_o.b.resp = w_err_q ? RespSlvErr : RespOkay;
        end
        if (r_valid) begin
            axi_resp_o.r.id   = r_id_q;
            axi_resp_o.r.data = r_in_range ? mem_q[r_idx] : '0;
            axi_resp_o.r.resp = r_in_range ? RespOkay : RespSlvErr;
            axi_resp_o.r.last = r_last;
        end
    end
endmodule
